// File: rtl/datapath_run_ctrl.sv
// Start/reset/run/dump sequencer for the single-cycle core; the dump is a valid/ready record stream.
// Optional macro RUN_CTRL_PC_TRACE_EN: emit a PC record every RUN cycle, with backpressure stalling the core.
module datapath_run_ctrl #(
  parameter int unsigned CYCLE_LIMIT  = 64,
  parameter int unsigned RESET_CYCLES = 1,
  parameter logic [31:0] MEM_BASE     = 32'h4000,
  parameter int unsigned MEM_WORDS    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        core_reset,
  output logic        core_en,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [1:0]  dump_kind,
  output logic [31:0] dump_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  halt_cause
);
  localparam int CW = $clog2(CYCLE_LIMIT + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int MW = ($clog2(MEM_WORDS) > 5) ? $clog2(MEM_WORDS) : 5;

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_RUN, S_DUMP_REG, S_DUMP_MEM, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [MW-1:0] idx_q, idx_d;
  logic [1:0]    hc_q, hc_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      idx_q   <= '0;
      hc_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      idx_q   <= idx_d;
      hc_q    <= hc_d;
    end
  end

  assign halt_cause = hc_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rcnt_d     = rcnt_q;
    idx_d      = idx_q;
    hc_d       = hc_q;
    core_reset = 1'b0;
    core_en    = 1'b0;
    dump_valid = 1'b0;
    dump_kind  = 2'd0;
    dump_data  = '0;
    rf_raddr   = '0;
    mem_raddr  = MEM_BASE;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        core_reset = 1'b1;
        busy       = 1'b0;
        done       = (state_q == S_DONE);
        if (start) begin
          state_d = S_RESET;
          cnt_d   = '0;
          rcnt_d  = '0;
          idx_d   = '0;
          hc_d    = 2'd0;
        end
      end
      S_RESET: begin
        core_reset = 1'b1;
        if (rcnt_q == RW'(RESET_CYCLES - 1)) state_d = S_RUN;
        else                                 rcnt_d  = rcnt_q + 1'b1;
      end
      S_RUN: begin
        dump_data = pc;
`ifdef RUN_CTRL_PC_TRACE_EN
        // The PC record is always presented; the core only steps when it is taken.
        dump_valid = 1'b1;
        core_en    = dump_ready && (inst != '0);
        if (dump_ready && (inst == '0)) begin
          hc_d    = 2'd1;
          state_d = S_DUMP_REG;
        end
`else
        core_en = (inst != '0);
        if (inst == '0) begin
          hc_d    = 2'd1;
          state_d = S_DUMP_REG;
        end
`endif
        if (core_en) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(CYCLE_LIMIT)) begin
            hc_d    = 2'd2;
            state_d = S_DUMP_REG;
          end
        end
      end
      S_DUMP_REG: begin
        dump_valid = 1'b1;
        dump_kind  = 2'd1;
        rf_raddr   = idx_q[4:0];
        dump_data  = rf_rdata;
        if (dump_ready) begin
          if (idx_q[4:0] == 5'd31) begin
            idx_d   = '0;
            state_d = S_DUMP_MEM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DUMP_MEM: begin
        dump_valid = 1'b1;
        dump_kind  = 2'd2;
        mem_raddr  = MEM_BASE + 32'(idx_q);
        dump_data  = mem_rdata;
        if (dump_ready) begin
          if (idx_q == MW'(MEM_WORDS - 1)) state_d = S_DONE;
          else                             idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Randomized bench for datapath_run_ctrl: a toy core model plus a record-level reference of each run.
module tb_datapath_run_ctrl;
  localparam int unsigned LIMIT = 4;
  localparam int unsigned RC    = 1;
  localparam logic [31:0] BASE  = 32'h4000;
  localparam int unsigned MW    = 4;
`ifdef RUN_CTRL_PC_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, dump_ready;
  logic        core_reset, core_en, dump_valid, busy, done;
  logic [31:0] inst, pc, rf_rdata, mem_raddr, mem_rdata, dump_data, mem_off;
  logic [4:0]  rf_raddr;
  logic [1:0]  dump_kind, halt_cause;

  always #5 clk = ~clk;

  datapath_run_ctrl #(
    .CYCLE_LIMIT(LIMIT), .RESET_CYCLES(RC), .MEM_BASE(BASE), .MEM_WORDS(MW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .core_reset(core_reset), .core_en(core_en),
    .inst(inst), .pc(pc),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_kind(dump_kind), .dump_data(dump_data),
    .busy(busy), .done(done), .halt_cause(halt_cause)
  );

  // Toy core: instruction ROM, register file and data memory with async reads.
  logic [31:0] prog [0:63];
  logic [31:0] rf   [0:31];
  logic [31:0] memw [0:MW-1];
  logic [31:0] core_pc = 32'd0;

  always @(posedge clk) begin
    if (core_reset)   core_pc <= 32'd0;
    else if (core_en) core_pc <= core_pc + 32'd4;
  end

  assign pc        = core_pc;
  assign inst      = prog[core_pc[7:2]];
  assign rf_rdata  = rf[rf_raddr];
  assign mem_off   = mem_raddr - BASE;
  assign mem_rdata = (mem_off < MW) ? memw[mem_off[1:0]] : 32'hdeadbeef;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
    logic [31:0] addr;
  } rec_t;

  rec_t expq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".core_reset"}, core_reset, 1);
    check({tag, ".core_en"},    core_en,    0);
    check({tag, ".dump_valid"}, dump_valid, 0);
    check({tag, ".dump_kind"},  dump_kind,  0);
    check({tag, ".busy"},       busy,       0);
    check({tag, ".done"},       done,       0);
    check({tag, ".halt_cause"}, halt_cause, 0);
    check({tag, ".rf_raddr"},   rf_raddr,   0);
    check({tag, ".mem_raddr"},  mem_raddr,  BASE);
  endtask

  // Reference: walk the program to get the accepted record sequence, step count and halt cause.
  task automatic build(output int steps, output logic [1:0] cause);
    logic [31:0] p;
    rec_t        r;
    expq.delete();
    steps = 0;
    cause = 2'd0;
    p     = 32'd0;
    for (int g = 0; g < 64; g++) begin
      if (TRACE) begin
        r.kind = 2'd0; r.data = p; r.addr = 32'd0;
        expq.push_back(r);
      end
      if (prog[p[7:2]] == 32'd0) begin cause = 2'd1; break; end
      steps++;
      p += 32'd4;
      if (steps == int'(LIMIT)) begin cause = 2'd2; break; end
    end
    for (int i = 0; i < 32; i++) begin
      r.kind = 2'd1; r.data = rf[i]; r.addr = i;
      expq.push_back(r);
    end
    for (int i = 0; i < int'(MW); i++) begin
      r.kind = 2'd2; r.data = memw[i]; r.addr = BASE + i;
      expq.push_back(r);
    end
  endtask

  // mode 0: always ready; 1: random ready; 2: ready low while running; 3: random plus forced stalls.
  task automatic run_once(input int mode, input int zero_at, input bit abort);
    int         exp_steps, k, stall_left;
    logic [1:0] cause;
    bit         running, stalled, finished, exp_en, exp_valid;
    rec_t       h;
    for (int i = 0; i < 64; i++) prog[i] = $urandom | 32'd1;
    if (zero_at >= 0) prog[zero_at] = 32'd0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    for (int i = 0; i < int'(MW); i++) memw[i] = $urandom;
    build(exp_steps, cause);

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    running = 0; stalled = 0; finished = 0; stall_left = 0; k = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      k++;
      if (k == int'(RC) + 1) running = 1;
      start = (k == int'(RC) + 2);
      if (mode == 3 && k == int'(RC) + 2) stall_left = 2;
      if (mode == 3 && !stalled && dump_valid && dump_kind == 2'd1 && rf_raddr == 5'd7) begin
        stalled = 1; stall_left = 3;
      end
      if (stall_left > 0) begin
        dump_ready = 1'b0; stall_left--;
      end else if (mode == 0) dump_ready = 1'b1;
      else if (mode == 2 && !TRACE && running) dump_ready = 1'b0;
      else dump_ready = ($urandom_range(0, 3) != 0);

      @(negedge clk);
      exp_en    = running && (inst != 32'd0) && (dump_ready || !TRACE);
      exp_valid = (k > int'(RC)) && (expq.size() > 0) && (TRACE || !running);
      check("core_reset", core_reset, (k <= int'(RC)));
      check("busy", busy, 1);
      check("done", done, 0);
      check("core_en", core_en, exp_en);
      check("halt_cause", halt_cause, (k <= int'(RC) || running) ? 2'd0 : cause);
      check("dump_valid", dump_valid, exp_valid);
      if (exp_valid) begin
        h = expq[0];
        if (abort && h.kind == 2'd2 && h.addr == BASE + 32'd1) begin
          reset = 1'b0;
          #1 check_reset_vals("abort");
          @(posedge clk); #1 reset = 1'b1;
          start = 1'b0;
          return;
        end
        check("dump_kind", dump_kind, h.kind);
        check("dump_data", dump_data, h.data);
        if (h.kind == 2'd1) check("rf_raddr", rf_raddr, h.addr);
        if (h.kind == 2'd2) check("mem_raddr", mem_raddr, h.addr);
        if (dump_ready) void'(expq.pop_front());
      end
      if (running) begin
        if (exp_en && core_pc + 32'd4 == 32'(4 * LIMIT)) running = 0;
        if (inst == 32'd0 && (dump_ready || !TRACE)) running = 0;
      end
      if (k > int'(RC) && expq.size() == 0) begin finished = 1; break; end
    end
    start = 1'b0;
    if (!finished) begin
      check("run_timeout", 0, 1);
      return;
    end
    @(posedge clk); @(negedge clk);
    check("end.done", done, 1);
    check("end.busy", busy, 0);
    check("end.dump_valid", dump_valid, 0);
    check("end.core_reset", core_reset, 1);
    check("end.halt_cause", halt_cause, cause);
    check("end.core_pc", core_pc, 32'(4 * exp_steps));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; dump_ready = 1'b0;
    #1 check_reset_vals("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run_once(0, -1, 0);
    run_once(1,  2, 0);
    run_once(3, -1, 0);
    run_once(2, -1, 0);
    run_once(1, -1, 1);
    run_once(1,  1, 0);
    run_once(2,  0, 0);
    for (int i = 0; i < 6; i++) run_once(int'($urandom_range(1, 3)), int'($urandom_range(0, 6)) - 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
